// File: rtl/eth_mac_conf_ctrl_pkg.sv
// Shared types for the MAC configuration controller: FSM states, vector bit map
// and the 80-bit configuration vector assembly used for both TX and RX vectors.
package eth_mac_conf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DISABLE,
    ST_SETTLE,
    ST_ENABLE
  } conf_state_t;

  localparam int MAC_MSB      = 79;
  localparam int MAC_LSB      = 32;
  localparam int FRM_MSB      = 30;
  localparam int FRM_LSB      = 16;
  localparam int JUMBO_BIT    = 4;
  localparam int VLAN_BIT     = 2;
  localparam int EN_BIT       = 1;
  localparam int RX_CONST_LSB = 8;
  localparam logic [1:0] RX_CONST = 2'b11;

  function automatic logic [79:0] conf_vec(
    input logic [47:0] mac,
    input logic [14:0] max_frame,
    input logic        jumbo,
    input logic        vlan,
    input logic        en,
    input logic        rx
  );
    logic [79:0] v;
    v                   = '0;
    v[MAC_MSB:MAC_LSB]  = mac;
    v[FRM_MSB:FRM_LSB]  = max_frame;
    v[JUMBO_BIT]        = jumbo;
    v[VLAN_BIT]         = vlan;
    v[EN_BIT]           = en;
    if (rx) v[RX_CONST_LSB +: 2] = RX_CONST;
    return v;
  endfunction

endpackage

// File: rtl/eth_mac_conf_ctrl_if.sv
// Configuration request channel: valid/ready handshake carrying MAC, jumbo and VLAN.
// The requester holds valid and payload stable until ready is seen.
interface eth_mac_conf_ctrl_if;
  logic        cfg_req_valid;
  logic        cfg_req_ready;
  logic [47:0] cfg_req_mac;
  logic        cfg_req_jumbo;
  logic        cfg_req_vlan;

  modport master (
    output cfg_req_valid, cfg_req_mac, cfg_req_jumbo, cfg_req_vlan,
    input  cfg_req_ready
  );

  modport slave (
    input  cfg_req_valid, cfg_req_mac, cfg_req_jumbo, cfg_req_vlan,
    output cfg_req_ready
  );
endinterface

// File: rtl/eth_mac_conf_ctrl_quiet_mon.sv
// Tracks TX frame boundaries and counts consecutive quiet cycles; quiet_done is
// combinational on the cycle the run reaches IDLE_CYCLES. No backpressure (monitor only).
module eth_tx_quiet_mon #(
  parameter int IDLE_CYCLES = 8
) (
  input  logic clk156,
  input  logic sys_rst,
  input  logic tvalid,
  input  logic tready,
  input  logic tlast,
  input  logic clr,
  output logic quiet_done
);

  localparam int CW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);

  logic          in_frame;
  logic [CW-1:0] cnt;
  logic          quiet;

  assign quiet      = !in_frame && !tvalid;
  assign quiet_done = !clr && quiet && (cnt == LAST);

  // Frame tracking runs regardless of clr so a frame already open at request time is seen.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      in_frame <= 1'b0;
      cnt      <= '0;
    end else begin
      if (tvalid && tready) in_frame <= !tlast;
      if (clr || !quiet)    cnt <= '0;
      else if (cnt != LAST) cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/eth_mac_conf_ctrl.sv
// Drains TX, disables the MAC, loads new MAC/jumbo/VLAN after a settle window, re-enables.
// Request ready only in IDLE; optional drain abort under ETH_CONF_DRAIN_TIMEOUT_EN.
module eth_mac_conf_ctrl
  import eth_mac_conf_pkg::*;
#(
  parameter logic [47:0] DEFAULT_MAC   = 48'h001122334455,
  parameter int          MAX_FRAME     = 1518,
  parameter int          IDLE_CYCLES   = 8,
  parameter int          SETTLE_CYCLES = 16,
  parameter int          DRAIN_TIMEOUT = 4096
) (
  input  logic                 clk156,
  input  logic                 sys_rst,
  eth_mac_conf_ctrl_if.slave   req,
  input  logic                 tx_axis_tvalid,
  input  logic                 tx_axis_tready,
  input  logic                 tx_axis_tlast,
  output logic                 tx_hold,
  output logic [79:0]          mac_tx_configuration_vector,
  output logic [79:0]          mac_rx_configuration_vector,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic [7:0]           cfg_count,
  output logic                 cfg_timeout
);

  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  if (IDLE_CYCLES < 1 || SETTLE_CYCLES < 1 || DRAIN_TIMEOUT < 1 || MAX_FRAME > 32767) begin : g_bad_cfg
    $error("eth_mac_conf_ctrl: invalid parameter set");
  end

  conf_state_t    state;
  logic [47:0]    mac_q, sh_mac;
  logic           jumbo_q, vlan_q, en_q;
  logic           sh_jumbo, sh_vlan;
  logic [SCW-1:0] settle_cnt;
  logic           accept;
  logic           quiet_done;
  logic           drain_expired;

  assign req.cfg_req_ready = (state == ST_IDLE);
  assign accept            = (state == ST_IDLE) && req.cfg_req_valid;

  assign mac_tx_configuration_vector = conf_vec(mac_q, 15'(MAX_FRAME), jumbo_q, vlan_q, en_q, 1'b0);
  assign mac_rx_configuration_vector = conf_vec(mac_q, 15'(MAX_FRAME), jumbo_q, vlan_q, en_q, 1'b1);

  eth_tx_quiet_mon #(.IDLE_CYCLES(IDLE_CYCLES)) u_quiet (
    .clk156     (clk156),
    .sys_rst    (sys_rst),
    .tvalid     (tx_axis_tvalid),
    .tready     (tx_axis_tready),
    .tlast      (tx_axis_tlast),
    .clr        (state != ST_DRAIN),
    .quiet_done (quiet_done)
  );

`ifdef ETH_CONF_DRAIN_TIMEOUT_EN
  localparam int DCW = $clog2(DRAIN_TIMEOUT + 1);
  logic [DCW-1:0] drain_cnt;

  assign drain_expired = (state == ST_DRAIN) && (drain_cnt == DCW'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk156) begin
    if (sys_rst || state != ST_DRAIN) drain_cnt <= '0;
    else                              drain_cnt <= drain_cnt + DCW'(1);

    if (sys_rst)                            cfg_timeout <= 1'b0;
    else if (accept)                        cfg_timeout <= 1'b0;
    else if (drain_expired && !quiet_done)  cfg_timeout <= 1'b1;
  end
`else
  assign drain_expired = 1'b0;
  assign cfg_timeout   = 1'b0;
`endif

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      mac_q      <= DEFAULT_MAC;
      jumbo_q    <= 1'b1;
      vlan_q     <= 1'b1;
      en_q       <= 1'b1;
      sh_mac     <= '0;
      sh_jumbo   <= 1'b0;
      sh_vlan    <= 1'b0;
      settle_cnt <= '0;
      tx_hold    <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_count  <= '0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sh_mac   <= req.cfg_req_mac;
            sh_jumbo <= req.cfg_req_jumbo;
            sh_vlan  <= req.cfg_req_vlan;
            tx_hold  <= 1'b1;
            cfg_busy <= 1'b1;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (quiet_done || drain_expired) state <= ST_DISABLE;
        end
        ST_DISABLE: begin
          en_q       <= 1'b0;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Fields only change while the MAC is disabled.
          if (settle_cnt == SETTLE_LAST) begin
            mac_q   <= sh_mac;
            jumbo_q <= sh_jumbo;
            vlan_q  <= sh_vlan;
            state   <= ST_ENABLE;
          end else begin
            settle_cnt <= settle_cnt + SCW'(1);
          end
        end
        ST_ENABLE: begin
          en_q     <= 1'b1;
          cfg_done <= 1'b1;
          tx_hold  <= 1'b0;
          cfg_busy <= 1'b0;
          if (cfg_count != 8'hFF) cfg_count <= cfg_count + 8'd1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mac_conf_ctrl.sv
// Directed bench for eth_mac_conf_ctrl: table-driven idle-link updates plus
// hand-written mid-frame, back-to-back, reset and (with macro) drain-timeout sequences.
module tb_eth_mac_conf_ctrl;

  logic        clk156 = 1'b0;
  logic        sys_rst;
  logic        tx_axis_tvalid, tx_axis_tready, tx_axis_tlast;
  logic        tx_hold, cfg_busy, cfg_done, cfg_timeout;
  logic [7:0]  cfg_count;
  logic [79:0] tx_vec, rx_vec;

  eth_mac_conf_ctrl_if req_if();

  eth_mac_conf_ctrl dut (
    .clk156                      (clk156),
    .sys_rst                     (sys_rst),
    .req                         (req_if),
    .tx_axis_tvalid              (tx_axis_tvalid),
    .tx_axis_tready              (tx_axis_tready),
    .tx_axis_tlast               (tx_axis_tlast),
    .tx_hold                     (tx_hold),
    .mac_tx_configuration_vector (tx_vec),
    .mac_rx_configuration_vector (rx_vec),
    .cfg_busy                    (cfg_busy),
    .cfg_done                    (cfg_done),
    .cfg_count                   (cfg_count),
    .cfg_timeout                 (cfg_timeout)
  );

  always #3 clk156 = ~clk156;

  typedef struct {
    logic [47:0] mac;
    logic        jumbo;
    logic        vlan;
    logic [79:0] exp_tx;
    logic [79:0] exp_rx;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [79:0] RST_TX = 80'h001122334455_05EE_0016;
  localparam logic [79:0] RST_RX = 80'h001122334455_05EE_0316;
  localparam logic [79:0] EN_MASK = 80'h2;

  task automatic tick(input int n);
    repeat (n) @(posedge clk156);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [47:0] mac, input logic jumbo, input logic vlan);
    req_if.cfg_req_valid = 1'b1;
    req_if.cfg_req_mac   = mac;
    req_if.cfg_req_jumbo = jumbo;
    req_if.cfg_req_vlan  = vlan;
  endtask

  // Advances until cfg_done is seen or the budget runs out; returns cycles waited.
  task automatic wait_done(input int limit, output bit got, output int waited);
    got = 1'b0;
    waited = 0;
    while (waited < limit && !got) begin
      tick(1);
      waited++;
      if (cfg_done === 1'b1) got = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    logic [79:0] prev_tx, prev_rx;
    bit          got, flag;
    int          waited, n;

    tbl[0] = '{48'hA0B1C2D3E4F5, 1'b0, 1'b1, 80'hA0B1C2D3E4F5_05EE_0006, 80'hA0B1C2D3E4F5_05EE_0306};
    tbl[1] = '{48'h000000000000, 1'b1, 1'b0, 80'h000000000000_05EE_0012, 80'h000000000000_05EE_0312};
    tbl[2] = '{48'hFFFFFFFFFFFF, 1'b1, 1'b1, 80'hFFFFFFFFFFFF_05EE_0016, 80'hFFFFFFFFFFFF_05EE_0316};
    tbl[3] = '{48'h5A5A5A5A5A5A, 1'b0, 1'b0, 80'h5A5A5A5A5A5A_05EE_0002, 80'h5A5A5A5A5A5A_05EE_0302};

    sys_rst = 1'b1;
    req_if.cfg_req_valid = 1'b0;
    req_if.cfg_req_mac   = '0;
    req_if.cfg_req_jumbo = 1'b0;
    req_if.cfg_req_vlan  = 1'b0;
    tx_axis_tvalid = 1'b0;
    tx_axis_tready = 1'b1;
    tx_axis_tlast  = 1'b0;
    tick(3);
    sys_rst = 1'b0;
    tick(1);

    check("rst_tx_vec", tx_vec, RST_TX);
    check("rst_rx_vec", rx_vec, RST_RX);
    check("rst_ready", req_if.cfg_req_ready, 1);
    check("rst_hold", tx_hold, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_done", cfg_done, 0);
    check("rst_count", cfg_count, 0);
    check("rst_timeout", cfg_timeout, 0);

    // Idle-link updates: handshake edge T0, sampling at T0+k means after edge T0+k-1.
    prev_tx = RST_TX;
    prev_rx = RST_RX;
    for (int i = 0; i < 4; i++) begin
      send_req(tbl[i].mac, tbl[i].jumbo, tbl[i].vlan);
      tick(1);
      req_if.cfg_req_valid = 1'b0;
      check("t1_hold", tx_hold, 1);
      check("t1_busy", cfg_busy, 1);
      check("t1_ready", req_if.cfg_req_ready, 0);
      tick(8);
      check("t9_en_still_on", tx_vec[1], 1);
      tick(1);
      check("t10_tx_disabled", tx_vec, prev_tx & ~EN_MASK);
      check("t10_rx_disabled", rx_vec, prev_rx & ~EN_MASK);
      tick(15);
      check("t25_old_fields", tx_vec, prev_tx & ~EN_MASK);
      tick(1);
      check("t26_tx_new_fields", tx_vec, tbl[i].exp_tx & ~EN_MASK);
      check("t26_rx_new_fields", rx_vec, tbl[i].exp_rx & ~EN_MASK);
      check("t26_done_low", cfg_done, 0);
      tick(1);
      check("t27_tx_final", tx_vec, tbl[i].exp_tx);
      check("t27_rx_final", rx_vec, tbl[i].exp_rx);
      check("t27_done", cfg_done, 1);
      check("t27_hold", tx_hold, 0);
      check("t27_busy", cfg_busy, 0);
      check("t27_ready", req_if.cfg_req_ready, 1);
      check("t27_count", cfg_count, 80'(i + 1));
      tick(1);
      check("t28_done_pulse", cfg_done, 0);
      prev_tx = tbl[i].exp_tx;
      prev_rx = tbl[i].exp_rx;
    end

    // Request lands inside a 40-beat frame; enables must hold until 8 quiet cycles after tlast.
    flag = 1'b0;
    for (int b = 0; b < 40; b++) begin
      tx_axis_tvalid = 1'b1;
      tx_axis_tready = 1'b1;
      tx_axis_tlast  = (b == 39);
      if (b == 5) send_req(48'h0123456789AB, 1'b1, 1'b1);
      tick(1);
      if (b == 5) begin
        req_if.cfg_req_valid = 1'b0;
        check("frame_hold", tx_hold, 1);
      end
      if (tx_vec[1] !== 1'b1 || rx_vec[1] !== 1'b1) flag = 1'b1;
    end
    tx_axis_tvalid = 1'b0;
    tx_axis_tlast  = 1'b0;
    tick(8);
    check("frame_no_drop", flag, 0);
    check("frame_en_tlast8", tx_vec[1], 1);
    tick(1);
    check("frame_en_off", tx_vec[1], 0);
    wait_done(40, got, waited);
    check("frame_done_seen", got, 1);
    check("frame_done_lat", waited, 17);
    check("frame_tx_final", tx_vec, 80'h0123456789AB_05EE_0016);
    check("frame_count", cfg_count, 5);

    // Second request held valid while busy is taken on the cfg_done cycle.
    send_req(48'h111111111111, 1'b0, 1'b0);
    tick(1);
    send_req(48'h222222222222, 1'b1, 1'b0);
    flag = 1'b0;
    n = 1;
    while (n < 60) begin
      tick(1);
      n++;
      if (cfg_done === 1'b1) break;
      if (req_if.cfg_req_ready !== 1'b0) flag = 1'b1;
    end
    check("b2b_done_lat", n, 27);
    check("b2b_ready_low", flag, 0);
    check("b2b_ready_on_done", req_if.cfg_req_ready, 1);
    check("b2b_first_vec", tx_vec, 80'h111111111111_05EE_0002);
    tick(1);
    req_if.cfg_req_valid = 1'b0;
    check("b2b_second_busy", cfg_busy, 1);
    check("b2b_second_hold", tx_hold, 1);
    wait_done(40, got, waited);
    check("b2b_second_done", got, 1);
    check("b2b_second_tx", tx_vec, 80'h222222222222_05EE_0012);
    check("b2b_second_rx", rx_vec, 80'h222222222222_05EE_0312);
    check("b2b_count", cfg_count, 7);

    // Reset in the middle of SETTLE discards the pending update.
    send_req(48'hDEADBEEF0001, 1'b0, 1'b0);
    tick(1);
    req_if.cfg_req_valid = 1'b0;
    tick(14);
    check("settle_en_off", tx_vec[1], 0);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    check("srst_tx", tx_vec, RST_TX);
    check("srst_rx", rx_vec, RST_RX);
    check("srst_hold", tx_hold, 0);
    check("srst_busy", cfg_busy, 0);
    check("srst_count", cfg_count, 0);
    check("srst_ready", req_if.cfg_req_ready, 1);
    tick(30);
    check("srst_discard_tx", tx_vec, RST_TX);
    check("srst_discard_done", cfg_done, 0);

`ifdef ETH_CONF_DRAIN_TIMEOUT_EN
    // Stalled TX: DRAIN gives up after 4096 cycles and the sequence completes.
    tx_axis_tvalid = 1'b1;
    tx_axis_tready = 1'b0;
    send_req(48'h0A0B0C0D0E0F, 1'b0, 1'b1);
    tick(1);
    req_if.cfg_req_valid = 1'b0;
    tick(4095);
    check("to_t4096_flag", cfg_timeout, 0);
    check("to_t4096_en", tx_vec[1], 1);
    tick(1);
    check("to_t4097_flag", cfg_timeout, 1);
    check("to_t4097_en", tx_vec[1], 1);
    tick(1);
    check("to_t4098_en", tx_vec[1], 0);
    tx_axis_tvalid = 1'b0;
    tx_axis_tready = 1'b1;
    wait_done(40, got, waited);
    check("to_done", got, 1);
    check("to_tx_final", tx_vec, 80'h0A0B0C0D0E0F_05EE_0006);
    check("to_sticky", cfg_timeout, 1);
    check("to_count", cfg_count, 1);
    send_req(48'h001122334455, 1'b1, 1'b1);
    tick(1);
    req_if.cfg_req_valid = 1'b0;
    check("to_clear_on_accept", cfg_timeout, 0);
    wait_done(40, got, waited);
    check("to_second_done", got, 1);
`else
    check("timeout_tied_low", cfg_timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
